// File: rtl/target_weight_loader_pkg.sv
// Shared DQN definitions: layer codes, loader FSM encoding and layer-size helper.
package target_weight_loader_pkg;

    localparam logic [1:0] LAYER_NONE = 2'b00;
    localparam logic [1:0] LAYER_H1   = 2'b01;
    localparam logic [1:0] LAYER_H2   = 2'b10;
    localparam logic [1:0] LAYER_OUT  = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_L1 = 3'd1,
        GAP_1   = 3'd2,
        LOAD_L2 = 3'd3,
        GAP_2   = 3'd4,
        LOAD_L3 = 3'd5,
        FINISH  = 3'd6
    } state_e;

    // Weights per layer: one word per (node, input) plus one bias per node.
    function automatic int unsigned layer_size(input int unsigned nodes, input int unsigned fan_in);
        return nodes * (fan_in + 1);
    endfunction

endpackage

// File: rtl/target_weight_loader.sv
// Copies main-net weights into the target net, layer by layer, one word per cycle.
module target_weight_loader
    import target_weight_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH                    = 32,
    parameter int unsigned LAYER_WIDTH                   = 2,
    parameter int unsigned NUMBER_OF_INPUT_NODE          = 2,
    parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int unsigned NUMBER_OF_OUTPUT_NODE         = 3,
    parameter int unsigned WEIGHT_COUNTER_WIDTH          = 11
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_start,
    output logic                            o_rd_en,
    output logic [LAYER_WIDTH-1:0]          o_rd_layer,
    output logic [WEIGHT_COUNTER_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0]           i_rd_data,
    output logic                            o_weight_valid,
    output logic                            o_rw_weight_select,
    output logic [LAYER_WIDTH-1:0]          o_weight_layer,
    output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
    output logic [DATA_WIDTH-1:0]           o_weight,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int unsigned CW = WEIGHT_COUNTER_WIDTH;
    localparam int unsigned LW = LAYER_WIDTH;

    localparam int unsigned N1 = layer_size(NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_INPUT_NODE);
    localparam int unsigned N2 = layer_size(NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_HIDDEN_NODE_LAYER_1);
    localparam int unsigned N3 = layer_size(NUMBER_OF_OUTPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_2);

    localparam logic [CW-1:0] LAST_L1 = CW'(N1 - 1);
    localparam logic [CW-1:0] LAST_L2 = CW'(N2 - 1);
    localparam logic [CW-1:0] LAST_L3 = CW'(N3 - 1);

    // Every layer's last address must be representable by the counter.
    if ((N1 > (2 ** CW)) || (N2 > (2 ** CW)) || (N3 > (2 ** CW))) begin : g_counter_width_check
        $error("target_weight_loader: WEIGHT_COUNTER_WIDTH too small for layer sizes");
    end

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            rd_en_q, rd_en_d;
    logic [LW-1:0]   rd_layer_q, rd_layer_d;
    logic [CW-1:0]   rd_addr_q, rd_addr_d;
    logic            wvalid_q, wvalid_d;
    logic [LW-1:0]   wlayer_q, wlayer_d;
    logic [CW-1:0]   waddr_q, waddr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // State, counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_en_q    <= 1'b0;
            rd_layer_q <= '0;
            rd_addr_q  <= '0;
            wvalid_q   <= 1'b0;
            wlayer_q   <= '0;
            waddr_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_en_q    <= rd_en_d;
            rd_layer_q <= rd_layer_d;
            rd_addr_q  <= rd_addr_d;
            wvalid_q   <= wvalid_d;
            wlayer_q   <= wlayer_d;
            waddr_q    <= waddr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next state, counter and next output values; read outputs follow the upcoming state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_en_d    = 1'b0;
        rd_layer_d = LW'(LAYER_NONE);
        rd_addr_d  = '0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = LOAD_L1;
                    cnt_d   = '0;
                end
            end
            LOAD_L1: begin
                if (cnt_q == LAST_L1) begin
                    state_d = GAP_1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP_1:   state_d = LOAD_L2;
            LOAD_L2: begin
                if (cnt_q == LAST_L2) begin
                    state_d = GAP_2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP_2:   state_d = LOAD_L3;
            LOAD_L3: begin
                if (cnt_q == LAST_L3) begin
                    state_d = FINISH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            LOAD_L1: begin
                rd_en_d    = 1'b1;
                rd_layer_d = LW'(LAYER_H1);
            end
            LOAD_L2: begin
                rd_en_d    = 1'b1;
                rd_layer_d = LW'(LAYER_H2);
            end
            LOAD_L3: begin
                rd_en_d    = 1'b1;
                rd_layer_d = LW'(LAYER_OUT);
            end
            default: begin
                rd_en_d    = 1'b0;
                rd_layer_d = LW'(LAYER_NONE);
            end
        endcase
        rd_addr_d = rd_en_d ? cnt_d : '0;

        busy_d   = (state_d != IDLE);
        done_d   = (state_q == FINISH);

        // Write side trails the read request by one cycle, matching RAM latency.
        wvalid_d = rd_en_q;
        wlayer_d = rd_en_q ? rd_layer_q : LW'(LAYER_NONE);
        waddr_d  = rd_en_q ? rd_addr_q : '0;
    end

    assign o_rd_en            = rd_en_q;
    assign o_rd_layer         = rd_layer_q;
    assign o_rd_addr          = rd_addr_q;
    assign o_weight_valid     = wvalid_q;
    assign o_weight_layer     = wlayer_q;
    assign o_weight_addr      = waddr_q;
    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_rw_weight_select = 1'b0;
    // RAM data arrives alongside the registered valid; held at zero otherwise.
    assign o_weight           = wvalid_q ? i_rd_data : '0;

endmodule

// File: tb/tb_target_weight_loader.sv
// Bench for target_weight_loader: synchronous RAM model plus timeline-based reference.
module tb_target_weight_loader;

    localparam int N1    = 96;
    localparam int N2    = 1056;
    localparam int N3    = 99;
    localparam int DONE_REL = N1 + N2 + N3 + 4;   // 1255
    localparam int LAST_BUSY = N1 + N2 + N3 + 3;  // 1254

    typedef struct packed {
        logic        rd_en;
        logic [1:0]  rd_layer;
        logic [10:0] rd_addr;
        logic        wv;
        logic        wsel;
        logic [1:0]  wlayer;
        logic [10:0] waddr;
        logic [31:0] weight;
        logic        busy;
        logic        done;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        o_rd_en;
    logic [1:0]  o_rd_layer;
    logic [10:0] o_rd_addr;
    logic [31:0] i_rd_data;
    logic        o_weight_valid;
    logic        o_rw_weight_select;
    logic [1:0]  o_weight_layer;
    logic [10:0] o_weight_addr;
    logic [31:0] o_weight;
    logic        o_busy;
    logic        o_done;

    logic [18:0] salt;
    int          checks;
    int          errors;

    target_weight_loader dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_start            (i_start),
        .o_rd_en            (o_rd_en),
        .o_rd_layer         (o_rd_layer),
        .o_rd_addr          (o_rd_addr),
        .i_rd_data          (i_rd_data),
        .o_weight_valid     (o_weight_valid),
        .o_rw_weight_select (o_rw_weight_select),
        .o_weight_layer     (o_weight_layer),
        .o_weight_addr      (o_weight_addr),
        .o_weight           (o_weight),
        .o_busy             (o_busy),
        .o_done             (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous main-net RAM: word content encodes its own layer and address.
    initial i_rd_data = '0;
    always @(posedge clk) begin
        if (o_rd_en) i_rd_data <= {salt, o_rd_layer, o_rd_addr};
    end

    // Which (layer, address) is read 'rel' cycles after i_start was sampled.
    function automatic bit read_at(input int rel, output logic [1:0] layer, output logic [10:0] addr);
        layer = 2'b00;
        addr  = '0;
        if (rel >= 1 && rel <= N1) begin
            layer = 2'b01; addr = 11'(rel - 1); return 1'b1;
        end
        if (rel >= N1 + 2 && rel <= N1 + 1 + N2) begin
            layer = 2'b10; addr = 11'(rel - (N1 + 2)); return 1'b1;
        end
        if (rel >= N1 + N2 + 3 && rel <= N1 + N2 + N3 + 2) begin
            layer = 2'b11; addr = 11'(rel - (N1 + N2 + 3)); return 1'b1;
        end
        return 1'b0;
    endfunction

    // Expected outputs 'rel' cycles after the start was sampled (rel<=0: idle).
    function automatic obs_t exp_at(input int rel, input logic [18:0] s);
        obs_t        e;
        logic [1:0]  l;
        logic [10:0] a;
        e = '0;
        if (read_at(rel, l, a)) begin
            e.rd_en = 1'b1; e.rd_layer = l; e.rd_addr = a;
        end
        if (read_at(rel - 1, l, a)) begin
            e.wv = 1'b1; e.wlayer = l; e.waddr = a; e.weight = {s, l, a};
        end
        e.busy = (rel >= 1 && rel <= LAST_BUSY);
        e.done = (rel == DONE_REL);
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.rd_en    = o_rd_en;
        o.rd_layer = o_rd_layer;
        o.rd_addr  = o_rd_addr;
        o.wv       = o_weight_valid;
        o.wsel     = o_rw_weight_select;
        o.wlayer   = o_weight_layer;
        o.waddr    = o_weight_addr;
        o.weight   = o_weight;
        o.busy     = o_busy;
        o.done     = o_done;
        return o;
    endfunction

    task automatic test_reset();
        obs_t o;
        rst_n   = 1'b0;
        i_start = 1'b1;
        salt    = 19'($urandom);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            o = observe();
            checks++;
            if (o !== obs_t'(0)) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", k, o, obs_t'(0));
            end
        end
        i_start = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_full_copy(input string tag);
        obs_t o, e;
        int   cnt1, cnt2, cnt3, done_cnt, done_cyc;
        int   idle;
        cnt1 = 0; cnt2 = 0; cnt3 = 0; done_cnt = 0; done_cyc = -1;
        salt = 19'($urandom);
        idle = $urandom_range(0, 15);
        for (int k = 0; k < idle; k++) begin
            @(negedge clk);
            o = observe(); e = exp_at(0, salt);
            o.weight = '0;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s idle got=%h exp=%h", tag, o, e);
            end
        end
        i_start = 1'b1;
        for (int k = 1; k <= DONE_REL + 5; k++) begin
            @(negedge clk);
            if (k == 1) i_start = 1'b0;
            o = observe(); e = exp_at(k, salt);
            if (!e.wv) o.weight = '0;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", tag, k, o, e);
            end
            if (o_weight_valid === 1'b1) begin
                if (o_weight_layer == 2'b01) cnt1++;
                if (o_weight_layer == 2'b10) cnt2++;
                if (o_weight_layer == 2'b11) cnt3++;
            end
            if (o_done === 1'b1) begin
                done_cnt++;
                done_cyc = k;
            end
        end
        checks += 4;
        if (cnt1 != N1) begin errors++; $display("FAIL %s l1_count got=%0d exp=%0d", tag, cnt1, N1); end
        if (cnt2 != N2) begin errors++; $display("FAIL %s l2_count got=%0d exp=%0d", tag, cnt2, N2); end
        if (cnt3 != N3) begin errors++; $display("FAIL %s l3_count got=%0d exp=%0d", tag, cnt3, N3); end
        if (done_cnt != 1 || done_cyc != DONE_REL) begin
            errors++;
            $display("FAIL %s done pulses=%0d at=%0d exp 1 at %0d", tag, done_cnt, done_cyc, DONE_REL);
        end
    endtask

    task automatic test_restart_ignored();
        obs_t o, e;
        int   r1, r2, done_cnt;
        done_cnt = 0;
        salt = 19'($urandom);
        r1 = $urandom_range(2, LAST_BUSY);
        r2 = $urandom_range(2, LAST_BUSY);
        i_start = 1'b1;
        for (int k = 1; k <= DONE_REL + 5; k++) begin
            @(negedge clk);
            i_start = (k == 500 || k == r1 || k == r2);
            o = observe(); e = exp_at(k, salt);
            if (!e.wv) o.weight = '0;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL restart cyc=%0d got=%h exp=%h", k, o, e);
            end
            if (o_done === 1'b1) done_cnt++;
        end
        i_start = 1'b0;
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL restart done_count got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        int   rlen;
        salt = 19'($urandom);
        rlen = $urandom_range(1, 3);
        i_start = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (k == 1) i_start = 1'b0;
            o = observe(); e = exp_at(k, salt);
            if (!e.wv) o.weight = '0;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL midreset cyc=%0d got=%h exp=%h", k, o, e);
            end
        end
        rst_n = 1'b0;
        for (int k = 0; k < rlen + 20; k++) begin
            @(negedge clk);
            if (k == rlen - 1) rst_n = 1'b1;
            o = observe();
            checks++;
            if (o !== obs_t'(0)) begin
                errors++;
                $display("FAIL midreset after=%0d got=%h exp=%h", k, o, obs_t'(0));
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        int   done_cnt;
        done_cnt = 0;
        salt = 19'($urandom);
        i_start = 1'b1;
        for (int k = 1; k <= 2 * DONE_REL + 5; k++) begin
            @(negedge clk);
            if (k == 2 * DONE_REL - 1) i_start = 1'b0;
            e = (k <= DONE_REL) ? exp_at(k, salt) : exp_at(k - DONE_REL, salt);
            o = observe();
            if (!e.wv) o.weight = '0;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", k, o, e);
            end
            if (o_done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 2) begin
            errors++;
            $display("FAIL b2b done_count got=%0d exp=2", done_cnt);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        i_start = 1'b0;
        salt    = '0;
        test_reset();
        test_full_copy("copy");
        test_restart_ignored();
        test_reset_mid();
        test_full_copy("copy_after_reset");
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/target_weight_loader.md
TARGET_WEIGHT_LOADER -- requirements
Module: target_weight_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, weight word width.
REQ-002 SHALL have parameter LAYER_WIDTH, default 2, layer code width (01 hidden1, 10 hidden2, 11 output, 00 none).
REQ-003 SHALL have parameters NUMBER_OF_INPUT_NODE=2, NUMBER_OF_HIDDEN_NODE_LAYER_1=32, NUMBER_OF_HIDDEN_NODE_LAYER_2=32, NUMBER_OF_OUTPUT_NODE=3, which set the layer sizes.
REQ-004 SHALL have parameter WEIGHT_COUNTER_WIDTH, default 11, weight address width.
REQ-005 SHALL use one clock and a synchronous, active-low reset, with ports clk (input, 1, rising-edge clock) and rst_n (input, 1, synchronous active-low reset).
REQ-006 SHALL have port i_start, input, 1, request to copy main-net weights into the target net.
REQ-007 SHALL have ports o_rd_en (output, 1), o_rd_layer (output, LAYER_WIDTH) and o_rd_addr (output, WEIGHT_COUNTER_WIDTH), forming the main-net weight RAM read request.
REQ-008 SHALL have port i_rd_data, input, DATA_WIDTH, RAM read data, valid one cycle after o_rd_en.
REQ-009 SHALL have ports o_weight_valid (output, 1), o_rw_weight_select (output, 1), o_weight_layer (output, LAYER_WIDTH), o_weight_addr (output, WEIGHT_COUNTER_WIDTH) and o_weight (output, DATA_WIDTH), which drive the target-net weight-write inputs.
REQ-010 SHALL have ports o_busy (output, 1, copy in progress) and o_done (output, 1, one-cycle completion pulse).

Function
REQ-011 SHALL use the layer sizes N1=NUMBER_OF_HIDDEN_NODE_LAYER_1*(NUMBER_OF_INPUT_NODE+1), N2=NUMBER_OF_HIDDEN_NODE_LAYER_2*(NUMBER_OF_HIDDEN_NODE_LAYER_1+1) and N3=NUMBER_OF_OUTPUT_NODE*(NUMBER_OF_HIDDEN_NODE_LAYER_2+1), which are 96, 1056 and 99 at the defaults.
REQ-012 SHALL use the address ordering node*(fan_in+1)+k with the bias at k=fan_in, so each layer's addresses run contiguously from 0 to Nx-1.
REQ-013 SHALL implement FSM states IDLE, LOAD_L1, GAP_1, LOAD_L2, GAP_2, LOAD_L3 and FINISH.
REQ-014 SHALL go from IDLE to LOAD_L1 when i_start is sampled high, with the address counter set to 0.
REQ-015 SHALL, in each LOAD state, assert o_rd_en every cycle, with o_rd_layer set to the state's layer code and o_rd_addr equal to the counter, which increments by 1 per cycle.
REQ-016 SHALL leave a LOAD state after issuing address Nx-1, going to the next GAP state (or to FINISH after L3), and clear the counter.
REQ-017 SHALL hold each GAP state for exactly one cycle with o_rd_en=0, then enter the next LOAD state.
REQ-018 SHALL stay in FINISH for exactly one cycle and then return to IDLE.
REQ-019 SHALL register o_weight_valid, o_weight_layer and o_weight_addr as the previous cycle's o_rd_en, o_rd_layer and o_rd_addr, and drive o_weight from i_rd_data, giving 1-cycle latency from read to write.
REQ-020 SHALL drive o_weight_layer=00 whenever o_weight_valid=0.
REQ-021 SHALL hold o_rw_weight_select at 0 (write mode) at all times.
REQ-022 SHALL assert o_busy in every state other than IDLE.
REQ-023 SHALL pulse o_done high for exactly one cycle, on the cycle after the last o_weight_valid (the FINISH state).
REQ-024 SHALL give this timeline at the defaults, with i_start sampled at cycle 0: reads at cycles 1-96, 98-1153 and 1155-1253, last o_weight_valid at cycle 1254, o_done at cycle 1255.
REQ-025 SHALL ignore i_start whenever it arrives outside IDLE; it is not queued.
REQ-026 SHALL start a new copy when i_start is high in the same cycle that FINISH returns to IDLE, because IDLE samples i_start.
REQ-027 SHALL make the address counter WEIGHT_COUNTER_WIDTH wide; N2-1 must fit, and an elaboration-time check SHALL fail if it does not.

Reset
REQ-028 SHALL, while rst_n is low at a clock edge, force the FSM to IDLE, the counter to 0, and o_rd_en, o_weight_valid, o_busy and o_done to 0.
REQ-029 SHALL reset o_rd_layer and o_weight_layer to 00, o_rd_addr and o_weight_addr to 0, and o_weight to 0.
REQ-030 SHALL abandon a copy that is reset mid-operation, with no o_done pulse, and SHALL require a fresh i_start to restart it.

Structure
REQ-031 SHALL place the layer codes (2'b01, 2'b10, 2'b11), the FSM state encoding and the layer-size expressions in the shared DQN package.
REQ-032 SHALL be implemented as a single module with no sub-modules; the read/write pipeline register is inline.

Verification
REQ-033 SHALL cover: i_start pulse with a RAM model whose data equals {layer,addr} -> 1251 o_weight_valid cycles, each o_weight matching its layer and addr, gap cycles at 97 and 1154, o_done at cycle 1255.
REQ-034 SHALL cover: per-layer valid-count check -> exactly 96, 1056 and 99 valids, with layer-1 addresses 0..95, layer-2 addresses 0..1055 and layer-3 addresses 0..98.
REQ-035 SHALL cover: i_start re-pulsed at cycle 500 -> no effect, and o_done still pulses once at cycle 1255.
REQ-036 SHALL cover: rst_n low at cycle 600 -> next cycle o_busy=0 and o_weight_valid=0, with no o_done; a new i_start then produces the full 1251-word sequence.
REQ-037 SHALL cover: i_start held high continuously -> back-to-back copies, with the second copy's first o_rd_en on the cycle after IDLE is re-entered.
REQ-038 SHALL cover: o_rw_weight_select checked every cycle -> always 0; o_weight_layer=00 whenever o_weight_valid=0.
